// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared definitions for the traffic sensor conditioner: channel FSM encoding,
// default parameter values and the counter-width helper.
package traffic_sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } chan_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 2;
  localparam int DEF_STUCK_CYCLES    = 64;

  // One width shared by every counter in a channel, wide enough for the largest limit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_sensor_channel.sv
// One detector channel: synchroniser, debounce, demand FSM and, with STUCK_DET_EN
// defined, a stuck-sensor detector that forces demand high while it is flagged.
module traffic_sensor_conditioner_sensor_channel
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  input  logic lite,
  output logic car,
  output logic fault
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable;
  logic [CW-1:0]          deb_cnt;
  logic                   flip;
  logic                   rise;

  chan_state_e            state_q, state_d;
  logic [CW-1:0]          hold_q, hold_d;
  logic                   fsm_car_q, fsm_car_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Stable flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  assign flip = (synced != stable) && (deb_cnt == DEB_LAST);
  assign rise = flip && synced;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else if (synced == stable) begin
      deb_cnt <= '0;
    end else if (flip) begin
      stable  <= synced;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      fsm_car_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      fsm_car_q <= fsm_car_d;
    end
  end

  // A debounced re-rise coinciding with release keeps the demand pending.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (stable) state_d = PENDING;
      end
      PENDING: begin
        if (lite) begin
          state_d = SERVING;
          hold_d  = '0;
        end
      end
      SERVING: begin
        if (!lite) begin
          state_d = (stable || rise) ? PENDING : IDLE;
          hold_d  = '0;
        end else if (stable) begin
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = rise ? PENDING : IDLE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    fsm_car_d = (state_d != IDLE);
  end

`ifdef STUCK_DET_EN
  localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);
  localparam logic [CW-1:0] STUCK_FULL = CW'(STUCK_CYCLES);

  logic [CW-1:0] run_cnt;
  logic          fault_q;

  always_ff @(posedge clock) begin
    if (!reset_n || !stable) begin
      run_cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      if (run_cnt != STUCK_FULL) run_cnt <= run_cnt + CW'(1);
      if (run_cnt == STUCK_LAST) fault_q <= 1'b1;
    end
  end

  // Fail-safe: a stuck sensor keeps requesting so the intersection keeps cycling.
  assign fault = fault_q;
  assign car   = fsm_car_q | fault_q;
`else
  assign fault = 1'b0;
  assign car   = fsm_car_q;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the EW/NS loop detectors into clean demand requests for TrafficLite.
// Optional stuck-sensor detection is enabled by defining STUCK_DET_EN.
module traffic_sensor_conditioner
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic EWRaw,
  input  logic NSRaw,
  input  logic EWLite,
  input  logic NSLite,
  output logic EWCar,
  output logic NSCar,
  output logic EWFault,
  output logic NSFault
);

  traffic_sensor_conditioner_sensor_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_ew (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (EWRaw),
    .lite   (EWLite),
    .car    (EWCar),
    .fault  (EWFault)
  );

  traffic_sensor_conditioner_sensor_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_ns (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (NSRaw),
    .lite   (NSLite),
    .car    (NSCar),
    .fault  (NSFault)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Randomised bench for traffic_sensor_conditioner against a behavioural model,
// plus short directed sequences for latency, glitch, service and stuck cases.
module tb_traffic_sensor_conditioner;

  localparam int S     = 2;
  localparam int DEB   = 4;
  localparam int HOLD  = 2;
  localparam int STUCK = 64;

  localparam int PH_NONE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_SRV  = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic EWRaw   = 1'b0;
  logic NSRaw   = 1'b0;
  logic EWLite  = 1'b0;
  logic NSLite  = 1'b0;
  logic EWCar, NSCar, EWFault, NSFault;

  int vectors     = 0;
  int miscompares = 0;

  bit m_pipe  [2][$];
  bit m_hist  [2][$];
  bit m_stable[2];
  int m_phase [2];
  int m_served[2];
  int m_run   [2];
  bit m_fault [2];
  bit m_car   [2];

  traffic_sensor_conditioner dut (
    .clock  (clock),
    .reset_n(reset_n),
    .EWRaw  (EWRaw),
    .NSRaw  (NSRaw),
    .EWLite (EWLite),
    .NSLite (NSLite),
    .EWCar  (EWCar),
    .NSCar  (NSCar),
    .EWFault(EWFault),
    .NSFault(NSFault)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_pipe[ch].delete();
      for (int i = 0; i < S; i++) m_pipe[ch].push_back(1'b0);
      m_hist[ch].delete();
      m_stable[ch] = 1'b0;
      m_phase[ch]  = PH_NONE;
      m_served[ch] = 0;
      m_run[ch]    = 0;
      m_fault[ch]  = 1'b0;
      m_car[ch]    = 1'b0;
    end
  endtask

  // Advance one channel of the model across one rising edge.
  task automatic model_edge(input int ch, input bit raw, input bit lite);
    bit synced, s, r;
    int diff;
    synced = m_pipe[ch].pop_front();
    m_pipe[ch].push_back(raw);
    m_hist[ch].push_back(synced);
    if (m_hist[ch].size() > DEB) void'(m_hist[ch].pop_front());
    s = m_stable[ch];
    r = 1'b0;
    if (m_hist[ch].size() == DEB) begin
      diff = 0;
      for (int i = 0; i < m_hist[ch].size(); i++)
        if (m_hist[ch][i] != s) diff++;
      if (diff == DEB) begin
        m_stable[ch] = ~s;
        r = ~s;
      end
    end
    case (m_phase[ch])
      PH_NONE: if (s) m_phase[ch] = PH_WAIT;
      PH_WAIT: if (lite) begin
        m_phase[ch]  = PH_SRV;
        m_served[ch] = 0;
      end
      default: begin
        if (!lite) begin
          m_phase[ch] = (s || r) ? PH_WAIT : PH_NONE;
        end else if (s) begin
          m_served[ch] = 0;
        end else begin
          m_served[ch]++;
          if (m_served[ch] >= HOLD) m_phase[ch] = r ? PH_WAIT : PH_NONE;
        end
      end
    endcase
`ifdef STUCK_DET_EN
    if (s) begin
      m_run[ch]++;
      if (m_run[ch] >= STUCK) m_fault[ch] = 1'b1;
    end else begin
      m_run[ch]   = 0;
      m_fault[ch] = 1'b0;
    end
`endif
    m_car[ch] = (m_phase[ch] != PH_NONE) || m_fault[ch];
  endtask

  task automatic step(input bit rn, input bit ew, input bit ns, input bit ewl, input bit nsl);
    reset_n = rn;
    EWRaw   = ew;
    NSRaw   = ns;
    EWLite  = ewl;
    NSLite  = nsl;
    @(posedge clock);
    if (!rn) model_reset();
    else begin
      model_edge(0, ew, ewl);
      model_edge(1, ns, nsl);
    end
    #1;
    chk("EWCar",   EWCar,   m_car[0]);
    chk("NSCar",   NSCar,   m_car[1]);
    chk("EWFault", EWFault, m_fault[0]);
    chk("NSFault", NSFault, m_fault[1]);
  endtask

  initial begin
    bit found;
    bit ew_v, ns_v, ewl_v, nsl_v;
    int ewd, nsd, ewld, nsld;

    // Reset with raw held high, then measure raw-to-Car latency.
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("T1 reset EWCar", EWCar, 0);
    chk("T1 reset NSFault", NSFault, 0);
    found = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step(1, 1, 1, 0, 0);
      if (!found && EWCar === 1'b1) begin
        found = 1'b1;
        chk("T1 latency", n, 7);
      end
    end
    if (!found) chk("T1 latency", 0, 7);

    // Short glitch rejected, full-length pulse latched.
    step(0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    repeat (10) step(1, 0, 0, 0, 0);
    chk("T2 glitch", EWCar, 0);
    repeat (4) step(1, 1, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0, 0);
    chk("T2 latched", EWCar, 1);

    // Service with car gone, then light leaving while car present.
    repeat (3) step(1, 0, 0, 1, 0);
    chk("T3 released", EWCar, 0);
    repeat (10) step(1, 1, 0, 0, 0);
    repeat (4) step(1, 1, 0, 1, 0);
    chk("T3 held", EWCar, 1);
    repeat (2) step(1, 1, 0, 0, 0);
    chk("T4 pending", EWCar, 1);

    // Both channels together; NS service must not disturb EW.
    step(0, 0, 0, 0, 0);
    repeat (8) step(1, 1, 1, 0, 0);
    chk("T5 EW", EWCar, 1);
    chk("T5 NS", NSCar, 1);
    repeat (10) step(1, 1, 0, 0, 1);
    chk("T5 NS served", NSCar, 0);
    chk("T5 EW kept", EWCar, 1);

    // Stuck NS sensor with the light toggling.
    step(0, 0, 0, 0, 0);
    for (int n = 0; n < 76; n++) step(1, 0, 1, 0, n[2]);
`ifdef STUCK_DET_EN
    chk("T6 fault set", NSFault, 1);
`else
    chk("T6 fault off", NSFault, 0);
`endif
    chk("T6 car", NSCar, 1);
    repeat (10) step(1, 0, 0, 0, 0);
    chk("T6 fault clear", NSFault, 0);

    // Randomised run with held levels of random length and rare resets.
    ew_v = 0; ns_v = 0; ewl_v = 0; nsl_v = 0;
    ewd = 0; nsd = 0; ewld = 0; nsld = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ewd == 0)  begin ew_v  = 1'($urandom_range(0, 1)); ewd  = $urandom_range(1, 9); end
      if (nsd == 0)  begin ns_v  = 1'($urandom_range(0, 1)); nsd  = $urandom_range(1, 9); end
      if (ewld == 0) begin ewl_v = 1'($urandom_range(0, 1)); ewld = $urandom_range(1, 6); end
      if (nsld == 0) begin nsl_v = 1'($urandom_range(0, 1)); nsld = $urandom_range(1, 6); end
      ewd--; nsd--; ewld--; nsld--;
      step(($urandom_range(0, 299) != 0), ew_v, ns_v, ewl_v, nsl_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
